// File: rtl/orientation_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : orientation_loader
// Purpose  : SPI front end for the cube-face display. Shifts in one face
//            orientation, synchronizes and validates it, then hands it to the
//            LED-matrix core with a one-cycle start pulse. Returns a done level
//            to the microcontroller once the core has drawn the face.
// Ports    : clk         - system clock (40 MHz)
//            reset       - synchronous, active-low reset
//            sck/sdi     - SPI clock/data, asynchronous to clk
//            load        - frame enable, asynchronous to clk, high for a frame
//            frame_done  - one-cycle pulse from the core: face written
//            orientation - displayed orientation, square k at [8k+7:8k]
//            start       - one-cycle pulse: new orientation valid
//            done        - level: last accepted frame has been displayed
//            err         - sticky: last frame was rejected
// Config   : ORIENT_CHECK_EN - when defined, CHECK also rejects any byte
//            greater than 5 (not a valid colour code).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module orientation_loader #(
  parameter int NUM_SQUARES     = 9,
  parameter int BITS_PER_SQUARE = 8,
  parameter int SYNC_STAGES     = 2,
  localparam int W              = NUM_SQUARES * BITS_PER_SQUARE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sck,
  input  logic         sdi,
  input  logic         load,
  input  logic         frame_done,
  output logic [W-1:0] orientation,
  output logic         start,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_CHECK = 3'd2,
    S_SHOW  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   sck_d;
  logic                   load_d;
  logic [W-1:0]           shadow;
  logic [6:0]             bitcnt;

  logic sck_s, sdi_s, load_s;
  logic sck_rise, load_rise, load_fall;
  logic bit_accept;
  logic codes_ok;
  logic frame_ok;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync[SYNC_STAGES-1];
  assign load_s = load_sync[SYNC_STAGES-1];

  assign sck_rise  = sck_s & ~sck_d;
  assign load_rise = load_s & ~load_d;
  assign load_fall = ~load_s & load_d;

  // load_d still high covers a bit whose rise coincides with the load fall.
  assign bit_accept = sck_rise & (load_s | load_d);

`ifdef ORIENT_CHECK_EN
  always_comb begin
    codes_ok = 1'b1;
    for (int k = 0; k < NUM_SQUARES; k++) begin
      if (shadow[k*BITS_PER_SQUARE +: BITS_PER_SQUARE] > BITS_PER_SQUARE'(5))
        codes_ok = 1'b0;
    end
  end
`else
  assign codes_ok = 1'b1;
`endif

  assign frame_ok = (bitcnt == 7'(W)) && codes_ok;

  // Synchronizer chains and one-cycle delayed copies used for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sck_sync  <= '0;
      sdi_sync  <= '0;
      load_sync <= '0;
      sck_d     <= 1'b0;
      load_d    <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      load_sync <= {load_sync[SYNC_STAGES-2:0], load};
      sck_d     <= sck_s;
      load_d    <= load_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      shadow      <= {W{1'b1}};
      orientation <= {W{1'b1}};
      bitcnt      <= 7'd0;
      start       <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_rise) begin
            bitcnt <= 7'd0;
            err    <= 1'b0;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bit_accept) begin
            shadow <= {shadow[W-2:0], sdi_s};
            if (bitcnt != 7'd127)
              bitcnt <= bitcnt + 7'd1;
          end
          if (load_fall)
            state <= S_CHECK;
        end
        S_CHECK: begin
          if (frame_ok) begin
            orientation <= shadow;
            start       <= 1'b1;
            state       <= S_SHOW;
          end else begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_SHOW: begin
          // The microcontroller must wait for done; an early frame is dropped.
          if (load_rise)
            err <= 1'b1;
          if (frame_done) begin
            done  <= 1'b1;
            state <= S_ACK;
          end
        end
        S_ACK: begin
          if (load_rise) begin
            done   <= 1'b0;
            bitcnt <= 7'd0;
            state  <= S_SHIFT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_orientation_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_orientation_loader
// Purpose  : Directed self-checking bench for orientation_loader. Frames are
//            shifted in over slow sck phases; expected values are hand-written.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_orientation_loader;

  localparam logic [71:0] ALL_FF = {72{1'b1}};
  localparam logic [71:0] GOOD1  = 72'h05_04_03_02_01_02_01_00_03;
  localparam logic [71:0] GOOD2  = 72'h00_01_02_03_04_05_00_01_02;
  localparam logic [71:0] BAD4   = 72'h00_01_02_03_07_05_04_03_02;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        load = 1'b0;
  logic        frame_done = 1'b0;
  logic [71:0] orientation;
  logic        start;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  orientation_loader dut (
    .clk         (clk),
    .reset       (reset),
    .sck         (sck),
    .sdi         (sdi),
    .load        (load),
    .frame_done  (frame_done),
    .orientation (orientation),
    .start       (start),
    .done        (done),
    .err         (err)
  );

  always #12.5 clk = ~clk;

  always @(negedge clk) if (start) start_cnt++;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // First bit sent is d[71]; bits beyond 72 are zeros.
  task automatic send_bits(input logic [71:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      sdi = (i < 72) ? d[71-i] : 1'b0;
      sck = 1'b0;
      cycles(5);
      sck = 1'b1;
      cycles(5);
    end
    sck = 1'b0;
    cycles(5);
  endtask

  // Drops load and records the cycle (1-based) of the start pulse, 0 if none.
  task automatic end_frame(output int pos);
    load = 1'b0;
    pos  = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (start && pos == 0) pos = c;
    end
  endtask

  task automatic begin_frame();
    load = 1'b1;
    cycles(6);
  endtask

  initial begin
    int pos;
    int sc0;

    // Reset
    reset = 1'b0;
    cycles(3);
    check("rst_orient", orientation, ALL_FF);
    check("rst_start", {71'd0, start}, 72'd0);
    check("rst_done", {71'd0, done}, 72'd0);
    check("rst_err", {71'd0, err}, 72'd0);
    reset = 1'b1;
    cycles(2);

    // Good frame
    sc0 = start_cnt;
    begin_frame();
    send_bits(GOOD1, 72);
    end_frame(pos);
    check("good_start_pos", {71'd0, (pos >= 4 && pos <= 5)}, 72'd1);
    check("good_start_cnt", 72'(start_cnt - sc0), 72'd1);
    check("good_orient", orientation, GOOD1);
    check("good_err", {71'd0, err}, 72'd0);
    check("good_done_pre", {71'd0, done}, 72'd0);

    // Display handshake
    frame_done = 1'b1;
    cycles(1);
    frame_done = 1'b0;
    check("hs_done_rise", {71'd0, done}, 72'd1);
    load = 1'b1;
    cycles(1);
    check("hs_done_hold", {71'd0, done}, 72'd1);
    cycles(5);
    check("hs_done_fall", {71'd0, done}, 72'd0);

    // Short frame (load already high, now in SHIFT)
    sc0 = start_cnt;
    send_bits(GOOD2, 71);
    end_frame(pos);
    check("short_err", {71'd0, err}, 72'd1);
    check("short_nostart", 72'(start_cnt - sc0), 72'd0);
    check("short_orient", orientation, GOOD1);

    // Long frame
    begin_frame();
    check("long_err_clr", {71'd0, err}, 72'd0);
    send_bits(GOOD2, 73);
    end_frame(pos);
    check("long_err", {71'd0, err}, 72'd1);
    check("long_nostart", 72'(start_cnt - sc0), 72'd0);
    check("long_orient", orientation, GOOD1);

    // Out-of-range colour code in byte 4
    sc0 = start_cnt;
    begin_frame();
    send_bits(BAD4, 72);
    end_frame(pos);
`ifdef ORIENT_CHECK_EN
    check("bad_err", {71'd0, err}, 72'd1);
    check("bad_nostart", 72'(start_cnt - sc0), 72'd0);
    check("bad_orient", orientation, GOOD1);
`else
    check("bad_err", {71'd0, err}, 72'd0);
    check("bad_start", 72'(start_cnt - sc0), 72'd1);
    check("bad_byte4", {64'd0, orientation[39:32]}, 72'h07);
`endif

    // Reset mid-frame, then a full good frame
    begin_frame();
    send_bits(GOOD2, 40);
    reset = 1'b0;
    load  = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(2);
    check("mid_rst_orient", orientation, ALL_FF);
    check("mid_rst_done", {71'd0, done}, 72'd0);
    check("mid_rst_err", {71'd0, err}, 72'd0);
    sc0 = start_cnt;
    begin_frame();
    send_bits(GOOD2, 72);
    end_frame(pos);
    check("mid_start_pos", {71'd0, (pos >= 4 && pos <= 5)}, 72'd1);
    check("mid_start_cnt", 72'(start_cnt - sc0), 72'd1);
    check("mid_orient", orientation, GOOD2);
    check("mid_err", {71'd0, err}, 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
